// File: rtl/state_trace_monitor.sv
// Watches an upstream state bus, logs every change as {prev, next, dwell} into a
// show-ahead FIFO drained over a valid/ready port; sticky overflow marks lost entries.
module state_trace_monitor #(
  parameter int unsigned STATE_W = 3,
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [STATE_W-1:0]       curr_state,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [STATE_W-1:0]       rd_prev_state,
  output logic [STATE_W-1:0]       rd_next_state,
  output logic [DWELL_W-1:0]       rd_dwell,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clear_ovf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0]   FULL_LVL  = LVL_W'(DEPTH);
  localparam logic [DWELL_W-1:0] DWELL_MAX = {DWELL_W{1'b1}};

  typedef struct packed {
    logic [STATE_W-1:0] prev;
    logic [STATE_W-1:0] next;
    logic [DWELL_W-1:0] dwell;
  } entry_t;

  logic               armed_q, armed_d;
  logic [STATE_W-1:0] st_q, st_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;

  logic               push_c;
  logic               pop_c;
  logic               wr_en_c;
  logic               drop_c;
  entry_t             wr_entry_c;

  // Change detection, dwell counting and FIFO bookkeeping
  always_comb begin
    armed_d          = 1'b1;
    st_d             = curr_state;
    dwell_d          = DWELL_W'(1);
    push_c           = 1'b0;
    wr_entry_c.prev  = st_q;
    wr_entry_c.next  = curr_state;
    wr_entry_c.dwell = dwell_q;

    if (armed_q) begin
      if (curr_state != st_q) begin
        push_c = 1'b1;
      end else begin
        st_d    = st_q;
        dwell_d = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + DWELL_W'(1);
      end
    end

    pop_c    = valid_q && rd_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    wr_en_c  = push_c && ((level_q != FULL_LVL) || pop_c);
    drop_c   = push_c && !wr_en_c;
    wr_ptr_d = wr_en_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_c   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q + LVL_W'(wr_en_c) - LVL_W'(pop_c);
    valid_d  = (level_d != '0);
    ovf_d    = drop_c | (ovf_q & ~clear_ovf);
  end

  // Control and pointer state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed_q  <= 1'b0;
      st_q     <= '0;
      dwell_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      armed_q  <= armed_d;
      st_q     <= st_d;
      dwell_q  <= dwell_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage; cleared so the read fields read zero out of reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_c) begin
      mem_q[wr_ptr_q] <= wr_entry_c;
    end
  end

  assign rd_valid      = valid_q;
  assign rd_prev_state = mem_q[rd_ptr_q].prev;
  assign rd_next_state = mem_q[rd_ptr_q].next;
  assign rd_dwell      = mem_q[rd_ptr_q].dwell;
  assign level         = level_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_state_trace_monitor.sv
// Bench for state_trace_monitor: directed scenarios plus randomized traffic against
// a queue-based reference model that derives dwell from cycle timestamps.
module tb_state_trace_monitor;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned DWELL_W = 8;
  localparam int unsigned DEPTH   = 8;
  localparam int          DMAX    = 255;

  typedef struct packed {
    logic [2:0] p;
    logic [2:0] n;
    logic [7:0] d;
  } ent_t;

  logic       clk        = 1'b0;
  logic       reset_n    = 1'b0;
  logic [2:0] curr_state = '0;
  logic       rd_ready   = 1'b0;
  logic       clear_ovf  = 1'b0;
  logic       rd_valid;
  logic [2:0] rd_prev_state;
  logic [2:0] rd_next_state;
  logic [7:0] rd_dwell;
  logic [3:0] level;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  ent_t       mq[$];
  bit         m_armed = 1'b0;
  bit         m_ovf   = 1'b0;
  logic [2:0] m_state = '0;
  int         m_cyc   = 0;
  int         m_start = 0;
  bit         mp_pop, mp_push, mp_drop;
  int         mp_len;
  ent_t       mp_e;

  always #5 clk = ~clk;

  state_trace_monitor #(
    .STATE_W(STATE_W),
    .DWELL_W(DWELL_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .curr_state   (curr_state),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_prev_state(rd_prev_state),
    .rd_next_state(rd_next_state),
    .rd_dwell     (rd_dwell),
    .level        (level),
    .overflow     (overflow),
    .clear_ovf    (clear_ovf)
  );

  // Reference model: dwell = edges since the state was first seen, capped at DMAX
  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      mq.delete();
      m_armed = 1'b0;
      m_ovf   = 1'b0;
      m_state = '0;
    end else begin
      m_cyc++;
      mp_pop  = (mq.size() != 0) && rd_ready;
      mp_push = m_armed && (curr_state != m_state);
      mp_drop = 1'b0;
      if (!m_armed) begin
        m_armed = 1'b1;
        m_state = curr_state;
        m_start = m_cyc;
      end else if (mp_push) begin
        mp_len  = m_cyc - m_start;
        mp_e    = '{p: m_state, n: curr_state, d: 8'((mp_len > DMAX) ? DMAX : mp_len)};
        m_state = curr_state;
        m_start = m_cyc;
      end
      if (mp_pop) void'(mq.pop_front());
      if (mp_push) begin
        if (mq.size() < int'(DEPTH)) mq.push_back(mp_e);
        else mp_drop = 1'b1;
      end
      if (mp_drop) m_ovf = 1'b1;
      else if (clear_ovf) m_ovf = 1'b0;
    end
  end

  task automatic do_reset(input logic [2:0] s);
    @(negedge clk);
    #2;
    reset_n    = 1'b0;
    curr_state = s;
    rd_ready   = 1'b0;
    clear_ovf  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 11; i++) begin
      curr_state = 3'(i * 5);
      #2;
      n_cmp++;
      if (rd_valid !== 1'b0 || level !== 4'd0 || overflow !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold t=%0t: valid=%b level=%0d ovf=%b, expected 0/0/0", $time, rd_valid, level, overflow);
      end
    end
    n_cmp++;
    if ({rd_prev_state, rd_next_state, rd_dwell} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_fields: got %h expected 0", {rd_prev_state, rd_next_state, rd_dwell});
    end
    curr_state = 3'd4;
    reset_n    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rd_valid !== 1'b0 || level !== 4'd0) begin
        n_err++;
        $display("FAIL reset_release cyc %0d: valid=%b level=%0d, expected 0/0", i, rd_valid, level);
      end
    end
  endtask

  task automatic test_single();
    do_reset(3'd0);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (level !== 4'd0) begin
      n_err++;
      $display("FAIL single_pre: level=%0d expected 0", level);
    end
    curr_state = 3'd1;
    @(negedge clk);
    n_cmp++;
    if (rd_valid !== 1'b1 || level !== 4'd1) begin
      n_err++;
      $display("FAIL single_level: valid=%b level=%0d expected 1/1", rd_valid, level);
    end
    n_cmp++;
    if (rd_prev_state !== 3'd0 || rd_next_state !== 3'd1 || rd_dwell !== 8'd4) begin
      n_err++;
      $display("FAIL single_entry: got {%0d,%0d,%0d} expected {0,1,4}", rd_prev_state, rd_next_state, rd_dwell);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (level !== 4'd1 || rd_dwell !== 8'd4) begin
      n_err++;
      $display("FAIL single_hold: level=%0d dwell=%0d expected 1/4", level, rd_dwell);
    end
  endtask

  task automatic test_saturation();
    do_reset(3'd2);
    repeat (300) @(negedge clk);
    curr_state = 3'd3;
    @(negedge clk);
    n_cmp++;
    if (level !== 4'd1 || rd_prev_state !== 3'd2 || rd_next_state !== 3'd3 || rd_dwell !== 8'd255) begin
      n_err++;
      $display("FAIL sat_entry: level=%0d {%0d,%0d,%0d} expected 1 {2,3,255}", level, rd_prev_state, rd_next_state, rd_dwell);
    end
  endtask

  task automatic test_overflow();
    logic [2:0] st [0:10];
    do_reset(3'd0);
    st[0] = 3'd0;
    for (int i = 1; i <= 9; i++) begin
      repeat (1 + $urandom % 3) @(negedge clk);
      if (i == 9) begin
        n_cmp++;
        if (level !== 4'd8 || overflow !== 1'b0) begin
          n_err++;
          $display("FAIL ovf_full: level=%0d ovf=%b expected 8/0", level, overflow);
        end
      end
      st[i] = st[i-1] ^ 3'(1 + $urandom % 7);
      curr_state = st[i];
    end
    @(negedge clk);
    n_cmp++;
    if (level !== 4'd8 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_drop: level=%0d ovf=%b expected 8/1", level, overflow);
    end
    n_cmp++;
    if (rd_prev_state !== st[0] || rd_next_state !== st[1]) begin
      n_err++;
      $display("FAIL ovf_head: got {%0d,%0d} expected {%0d,%0d}", rd_prev_state, rd_next_state, st[0], st[1]);
    end
    st[10] = st[9] ^ 3'(1 + $urandom % 7);
    curr_state = st[10];
    rd_ready   = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    n_cmp++;
    if (level !== 4'd8 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_pushpop: level=%0d ovf=%b expected 8/1", level, overflow);
    end
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear: ovf=%b expected 0", overflow);
    end
    rd_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (rd_valid !== 1'b1 || mq.size() == 0 ||
          {rd_prev_state, rd_next_state, rd_dwell} !== mq[0]) begin
        n_err++;
        $display("FAIL ovf_drain %0d: valid=%b got {%0d,%0d,%0d} model size %0d", k, rd_valid,
                 rd_prev_state, rd_next_state, rd_dwell, mq.size());
      end
      if (k == 0 || k == 7) begin
        n_cmp++;
        if (rd_prev_state !== st[k == 0 ? 1 : 9] || rd_next_state !== st[k == 0 ? 2 : 10]) begin
          n_err++;
          $display("FAIL ovf_order %0d: got {%0d,%0d} expected {%0d,%0d}", k, rd_prev_state, rd_next_state,
                   st[k == 0 ? 1 : 9], st[k == 0 ? 2 : 10]);
        end
      end
      @(negedge clk);
    end
    rd_ready = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b0 || level !== 4'd0) begin
      n_err++;
      $display("FAIL ovf_empty: valid=%b level=%0d expected 0/0", rd_valid, level);
    end
  endtask

  task automatic test_drain_order();
    logic [2:0] seq  [0:4] = '{3'd0, 3'd1, 3'd3, 3'd7, 3'd6};
    int         hold [0:3] = '{3, 2, 5, 1};
    do_reset(3'd0);
    for (int i = 0; i < 4; i++) begin
      repeat (hold[i]) @(negedge clk);
      curr_state = seq[i+1];
    end
    @(negedge clk);
    n_cmp++;
    if (level !== 4'd4) begin
      n_err++;
      $display("FAIL drain_level: level=%0d expected 4", level);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_prev_state !== seq[i] || rd_next_state !== seq[i+1] ||
          rd_dwell !== 8'(hold[i])) begin
        n_err++;
        $display("FAIL drain_entry %0d: valid=%b {%0d,%0d,%0d} expected 1 {%0d,%0d,%0d}", i, rd_valid,
                 rd_prev_state, rd_next_state, rd_dwell, seq[i], seq[i+1], hold[i]);
      end
      @(negedge clk);
    end
    rd_ready = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b0 || level !== 4'd0) begin
      n_err++;
      $display("FAIL drain_empty: valid=%b level=%0d expected 0/0", rd_valid, level);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(3'd0);
    repeat (2) @(negedge clk);
    curr_state = 3'd2;
    repeat (2) @(negedge clk);
    curr_state = 3'd5;
    repeat (2) @(negedge clk);
    curr_state = 3'd4;
    @(negedge clk);
    n_cmp++;
    if (level !== 4'd3) begin
      n_err++;
      $display("FAIL mid_pre: level=%0d expected 3", level);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (rd_valid !== 1'b0 || level !== 4'd0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL mid_async: valid=%b level=%0d ovf=%b expected 0/0/0", rd_valid, level, overflow);
    end
    curr_state = 3'd5;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (level !== 4'd0) begin
        n_err++;
        $display("FAIL mid_rearm %0d: level=%0d expected 0", i, level);
      end
    end
    curr_state = 3'd1;
    @(negedge clk);
    n_cmp++;
    if (level !== 4'd1 || rd_prev_state !== 3'd5 || rd_next_state !== 3'd1 || rd_dwell !== 8'd3) begin
      n_err++;
      $display("FAIL mid_entry: level=%0d {%0d,%0d,%0d} expected 1 {5,1,3}", level, rd_prev_state, rd_next_state, rd_dwell);
    end
  endtask

  task automatic test_random();
    do_reset(3'($urandom));
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rd_valid !== (mq.size() != 0) || level !== 4'(mq.size()) || overflow !== m_ovf) begin
        n_err++;
        $display("FAIL rnd_status cyc %0d: valid=%b level=%0d ovf=%b expected %b/%0d/%b", i, rd_valid, level,
                 overflow, mq.size() != 0, mq.size(), m_ovf);
      end
      if (mq.size() != 0) begin
        n_cmp++;
        if ({rd_prev_state, rd_next_state, rd_dwell} !== mq[0]) begin
          n_err++;
          $display("FAIL rnd_head cyc %0d: got {%0d,%0d,%0d} expected {%0d,%0d,%0d}", i, rd_prev_state,
                   rd_next_state, rd_dwell, mq[0].p, mq[0].n, mq[0].d);
        end
      end
      if ($urandom % 2 == 0) curr_state = 3'($urandom);
      rd_ready  = ($urandom % 4 == 0);
      clear_ovf = ($urandom % 16 == 0);
    end
    rd_ready  = 1'b0;
    clear_ovf = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturation();
    test_overflow();
    test_drain_order();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/state_trace_monitor.md
Name: state_trace_monitor

Overview:
Downstream consumer of the state transition controller's curr_state output. Samples the state every clock and detects changes. Each transition is logged as an entry {previous state, new state, dwell cycles} into a small show-ahead FIFO. A valid/ready read port drains the log to a debug/scoreboard consumer; a sticky overflow flag reports lost transitions.

Parameters:
STATE_W, 3, width of the monitored state bus
DWELL_W, 8, width of the dwell counter (saturating)
DEPTH, 8, FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
curr_state  input  STATE_W  state from the upstream controller, sampled every rising edge
rd_valid  output  1  head entry available
rd_ready  input  1  consumer accepts head entry when rd_valid && rd_ready
rd_prev_state  output  STATE_W  head entry: state before the transition
rd_next_state  output  STATE_W  head entry: state after the transition
rd_dwell  output  DWELL_W  head entry: cycles rd_prev_state was held, saturated
level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
overflow  output  1  sticky: a transition was dropped because the FIFO was full
clear_ovf  input  1  synchronous clear of overflow

Behaviour:
- Reset (async assert, sync release by the system): armed=0, st_q=0, dwell_cnt=0, FIFO empty.
- Reset outputs: rd_valid=0, level=0, overflow=0, rd_* fields=0.
- Reset mid-operation: all logged entries are discarded and the monitor re-arms.
- Arm cycle: first rising edge with reset_n=1 sets st_q<=curr_state, dwell_cnt<=1, armed<=1. No entry is generated.
- Armed, curr_state==st_q: dwell_cnt<=min(dwell_cnt+1, 2^DWELL_W-1). Saturates and holds at max.
- Armed, curr_state!=st_q (transition): push {st_q, curr_state, dwell_cnt}; st_q<=curr_state; dwell_cnt<=1.
- Detection latency: the entry is visible on rd_* / rd_valid one cycle after the edge that sampled the new state.
- FIFO: show-ahead. rd_* always shows the head entry while rd_valid=1. rd_* are don't-care (hold last) when rd_valid=0.
- Pop occurs on rd_valid && rd_ready. The next entry appears the following cycle.
- rd_valid = (level != 0). Pointers wrap modulo DEPTH.
- Push when level<DEPTH: accepted, level+1 (unless a simultaneous pop).
- Push when level==DEPTH and no pop: entry dropped, overflow<=1, FIFO unchanged.
- Push when level==DEPTH with simultaneous pop: both succeed, level stays DEPTH, no overflow.
- Pop and push when level==0: push only; a pop is impossible since rd_valid=0.
- rd_ready with rd_valid=0: ignored.
- overflow: set by a drop, cleared by clear_ovf. If a drop and clear_ovf occur in the same cycle, set wins.
- curr_state X/unknown values are not handled; the upstream guarantees a defined state after reset.

Test Plan:
- Reset hold: reset_n=0 for 22 time units, curr_state toggling -> rd_valid=0, level=0, overflow=0 throughout; no entry after release until a real change post-arm.
- Single transition: arm with curr_state=0, hold 0 for 4 cycles total, then curr_state=1 held, rd_ready=0 -> one entry {prev=0, next=1, dwell=4}, level=1.
- Dwell saturation: DWELL_W=8, hold state 2 for 300 cycles then change to 3 -> entry dwell=255.
- Overflow and simultaneous push/pop: rd_ready=0, generate 9 transitions (DEPTH=8) -> level=8, overflow=1, 9th entry absent. Then hold rd_ready=1 while another transition arrives at full -> level stays 8, new entry appended. clear_ovf -> overflow=0.
- Drain ordering: log transitions 0->1->3->7->6, then rd_ready=1 -> entries read in order {0,1},{1,3},{3,7},{7,6} with correct dwells; rd_valid deasserts after the last; level back to 0.
- Reset mid-operation: 3 entries logged, assert reset_n=0 asynchronously between edges -> rd_valid and level drop to 0 immediately. After release, the first edge arms with no entry generated.
